fx_param_ctrl: RTL

Second-generation effect-parameter controller. It turns the board switches and the debounced inc, dec and restore-default keys into edits of a FX_COUNT × PARAM_COUNT parameter bank. The bank feeds the audio effect chain. Compared with the first-generation controller it adds:
- hold-to-repeat with acceleration,
- saturating arithmetic,
- a per-parameter restore-default key,
- a change strobe for downstream reload logic.

---
 rtl/fx_param_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/fx_param_ctrl.sv
// Effect-parameter controller: switch-selected parameter bank edited by
// debounced inc/dec/restore-default keys, with hold-to-repeat, acceleration,
// saturating arithmetic and a change strobe for downstream reload logic.

package lab_pkg;
    localparam int unsigned INCDEC_AMOUNT = 5;

    // Power-on value of params[f][p]; callers truncate to the parameter width.
    function automatic int unsigned param_default(input int unsigned f, input int unsigned p);
        return (f * 7 + p * 13 + 20) % 128;
    endfunction
endpackage

module fx_param_ctrl #(
    parameter int FX_COUNT         = 16,
    parameter int PARAM_COUNT      = 8,
    parameter int PARAM_W          = 7,
    parameter int DEBOUNCE_CNT_MAX = 50000,
    parameter int STEP             = lab_pkg::INCDEC_AMOUNT,
    parameter int REPEAT_DELAY     = 25000000,
    parameter int REPEAT_RATE      = 5000000,
    parameter int ACCEL_AFTER      = 8,
    parameter int ACCEL_MULT       = 4
) (
    input  logic                                                    clk,
    input  logic                                                    reset_n,
    input  logic [(FX_COUNT > 1 ? $clog2(FX_COUNT) : 1)-1:0]        sw_fx_sel,
    input  logic [(PARAM_COUNT > 1 ? $clog2(PARAM_COUNT) : 1)-1:0]  sw_param_sel,
    input  logic                                                    key_inc,
    input  logic                                                    key_dec,
    input  logic                                                    key_def,
    output logic [PARAM_W-1:0]                                      params [0:FX_COUNT-1][0:PARAM_COUNT-1],
    output logic [(FX_COUNT > 1 ? $clog2(FX_COUNT) : 1)-1:0]        fx_sel,
    output logic [(PARAM_COUNT > 1 ? $clog2(PARAM_COUNT) : 1)-1:0]  param_sel,
    output logic [PARAM_W-1:0]                                      current_value,
    output logic                                                    param_changed
);

    localparam int FX_W    = FX_COUNT > 1 ? $clog2(FX_COUNT) : 1;
    localparam int PS_W    = PARAM_COUNT > 1 ? $clog2(PARAM_COUNT) : 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CNT_MAX + 1);
    localparam int TMR_MAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int REP_W   = $clog2(ACCEL_AFTER + 2);
    localparam int VMAX_I  = (2 ** PARAM_W) - 1;
    localparam int BASE_I  = STEP > VMAX_I ? VMAX_I : STEP;
    localparam int ACC_I   = STEP * ACCEL_MULT > VMAX_I ? VMAX_I : STEP * ACCEL_MULT;

    // Step amounts are pre-clamped to the value range so the sum fits PARAM_W+1 bits.
    localparam logic [PARAM_W:0] BASE_AMT = (PARAM_W + 1)'(BASE_I);
    localparam logic [PARAM_W:0] ACC_AMT  = (PARAM_W + 1)'(ACC_I);
    localparam logic [PARAM_W:0] LIM      = {1'b0, {PARAM_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_HOLD} state_t;

    logic [FX_W-1:0]    fx_s1, fx_s2, fx_prev;
    logic [PS_W-1:0]    ps_s1, ps_s2, ps_prev;
    logic [2:0]         key_raw, k_s1, k_s2, db, db_prev;
    logic [DB_W-1:0]    db_cnt [3];
    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               dir_q, dir_d;
    logic               step_req, step_up, step_acc;
    logic               inc_rise, dec_rise, def_rise, both, held, sel_chg;
    logic [PARAM_W:0]   amt, sum, diff;
    logic [PARAM_W-1:0] up_val, dn_val, def_val, wr_val;
    logic               wr_en;

    assign key_raw = {key_def, key_dec, key_inc};

    // Two-flop synchronisers for the select switch buses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fx_s1 <= '0;
            fx_s2 <= '0;
            ps_s1 <= '0;
            ps_s2 <= '0;
        end else begin
            fx_s1 <= sw_fx_sel;
            fx_s2 <= fx_s1;
            ps_s1 <= sw_param_sel;
            ps_s2 <= ps_s1;
        end
    end

    // Out-of-range switch codes clamp to the last effect/parameter.
    generate
        if (FX_COUNT == (2 ** FX_W)) begin : g_fx_direct
            assign fx_sel = fx_s2;
        end else begin : g_fx_clamp
            assign fx_sel = (fx_s2 > FX_W'(FX_COUNT - 1)) ? FX_W'(FX_COUNT - 1) : fx_s2;
        end
        if (PARAM_COUNT == (2 ** PS_W)) begin : g_ps_direct
            assign param_sel = ps_s2;
        end else begin : g_ps_clamp
            assign param_sel = (ps_s2 > PS_W'(PARAM_COUNT - 1)) ? PS_W'(PARAM_COUNT - 1) : ps_s2;
        end
    endgenerate

    // Per-key synchroniser and stable-level counter; the level flips after
    // DEBOUNCE_CNT_MAX consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_s1    <= '0;
            k_s2    <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            k_s1    <= key_raw;
            k_s2    <= k_s1;
            db_prev <= db;
            for (int unsigned i = 0; i < 3; i++) begin
                if (k_s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CNT_MAX - 1)) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign inc_rise = db[0] & ~db_prev[0];
    assign dec_rise = db[1] & ~db_prev[1];
    assign def_rise = db[2] & ~db_prev[2];
    assign both     = db[0] & db[1];
    assign held     = dir_q ? db[0] : db[1];
    assign sel_chg  = (fx_sel != fx_prev) || (param_sel != ps_prev);

    // Key FSM state, repeat timer, repeat-step count and selection history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            rep_q   <= '0;
            dir_q   <= 1'b0;
            fx_prev <= '0;
            ps_prev <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rep_q   <= rep_d;
            dir_q   <= dir_d;
            fx_prev <= fx_sel;
            ps_prev <= param_sel;
        end
    end

    // Next-state and step requests; restore-default pre-empts any step.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rep_d    = rep_q;
        dir_d    = dir_q;
        step_req = 1'b0;
        step_up  = dir_q;
        step_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (both) begin
                    state_d = S_HOLD;
                end else if (inc_rise || dec_rise) begin
                    step_req = 1'b1;
                    step_up  = inc_rise;
                    dir_d    = inc_rise;
                    timer_d  = '0;
                    rep_d    = '0;
                    state_d  = (REPEAT_DELAY == 0) ? S_HOLD : S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (both || sel_chg) begin
                    state_d = S_HOLD;
                end else if (!held) begin
                    state_d = S_IDLE;
                end else if (timer_q == ((state_q == S_DELAY) ? TMR_W'(REPEAT_DELAY - 1)
                                                               : TMR_W'(REPEAT_RATE - 1))) begin
                    step_req = 1'b1;
                    step_acc = (rep_q >= REP_W'(ACCEL_AFTER));
                    timer_d  = '0;
                    state_d  = S_REPEAT;
                    if (rep_q != REP_W'(ACCEL_AFTER)) rep_d = rep_q + 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!db[0] && !db[1]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (def_rise) begin
            if (step_req || state_q != S_IDLE) state_d = S_HOLD;
            step_req = 1'b0;
        end
    end

    // Saturating step arithmetic and write-data selection.
    always_comb begin
        amt     = step_acc ? ACC_AMT : BASE_AMT;
        sum     = {1'b0, current_value} + amt;
        diff    = {1'b0, current_value} - amt;
        up_val  = (sum > LIM) ? '1 : sum[PARAM_W-1:0];
        dn_val  = (amt > {1'b0, current_value}) ? '0 : diff[PARAM_W-1:0];
        def_val = PARAM_W'(lab_pkg::param_default(32'(fx_sel), 32'(param_sel)));
        wr_en   = def_rise | step_req;
        wr_val  = def_rise ? def_val : (step_up ? up_val : dn_val);
    end

    assign current_value = params[fx_sel][param_sel];

    // Parameter bank: only the selected entry is ever written after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned f = 0; f < FX_COUNT; f++)
                for (int unsigned p = 0; p < PARAM_COUNT; p++)
                    params[f][p] <= PARAM_W'(lab_pkg::param_default(f, p));
            param_changed <= 1'b0;
        end else begin
            if (wr_en) params[fx_sel][param_sel] <= wr_val;
            param_changed <= wr_en && (wr_val != current_value);
        end
    end

endmodule
